// File: rtl/knight_move_sequencer_if.sv
// Bus bundle for the knight move sequencer: host request/result signals
// plus the scanner handshake (board/position/direction out, target/piece back).
interface knight_move_sequencer_if;
   logic         start;
   logic         abort;
   logic [5:0]   square;
   logic         side;
   logic [255:0] board_in;
   logic [255:0] scan_board;
   logic [5:0]   scan_pos;
   logic [2:0]   scan_dir;
   logic [5:0]   scan_target;
   logic [3:0]   scan_piece;
   logic         busy;
   logic         done;
   logic [63:0]  move_mask;
   logic [63:0]  capture_mask;
   logic [3:0]   move_count;

   // Host side, which also plays the scanner
   modport master (
      output start, abort, square, side, board_in, scan_target, scan_piece,
      input  scan_board, scan_pos, scan_dir, busy, done,
             move_mask, capture_mask, move_count
   );

   // Sequencer side
   modport slave (
      input  start, abort, square, side, board_in, scan_target, scan_piece,
      output scan_board, scan_pos, scan_dir, busy, done,
             move_mask, capture_mask, move_count
   );
endinterface

// File: rtl/knight_move_sequencer.sv
// Knight move sequencer: steps an external scanner through the eight knight
// directions from a latched origin square and accumulates legal-move and
// capture masks plus a move count.
module knight_move_sequencer #(
   parameter int SCAN_LAT = 1
) (
   input logic                    clk,
   input logic                    rst_n,
   knight_move_sequencer_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   // Last value of the WAIT counter; scanner result is taken on the edge leaving it
   localparam logic [1:0] WAIT_LAST = 2'(SCAN_LAT - 1);

   state_t       state, state_nx;
   logic [1:0]   wait_cnt;
   logic         side_q;
   logic [255:0] board_q;
   logic [5:0]   pos_q;
   logic [2:0]   dir_q;
   logic [63:0]  mask_q;
   logic [63:0]  cap_q;
   logic [3:0]   cnt_q;
   logic         accept;
   logic         capture;
   logic         legal;
   logic         is_capture;

   // True when the knight jump in direction dir stays on the board
   function automatic logic on_board(input logic [5:0] pos, input logic [2:0] dir);
      logic [2:0] col;
      logic [2:0] row;
      col = pos[2:0];
      row = pos[5:3];
      case (dir)
         3'd0:    on_board = (col >= 3'd2) && (row >= 3'd1);
         3'd1:    on_board = (col >= 3'd1) && (row >= 3'd2);
         3'd2:    on_board = (col <= 3'd6) && (row >= 3'd2);
         3'd3:    on_board = (col <= 3'd5) && (row >= 3'd1);
         3'd4:    on_board = (col <= 3'd5) && (row <= 3'd6);
         3'd5:    on_board = (col <= 3'd6) && (row <= 3'd5);
         3'd6:    on_board = (col >= 3'd1) && (row <= 3'd5);
         default: on_board = (col >= 3'd2) && (row <= 3'd6);
      endcase
   endfunction

   assign accept = (state == IDLE) && bus.start;

   // Next-state logic; capture marks the edge that takes the scanner result
   always_comb begin
      state_nx = state;
      capture  = 1'b0;
      case (state)
         IDLE:  if (bus.start) state_nx = ISSUE;
         ISSUE: state_nx = bus.abort ? IDLE : WAIT;
         WAIT: begin
            if (bus.abort) begin
               state_nx = IDLE;
            end else if (wait_cnt == WAIT_LAST) begin
               capture  = 1'b1;
               state_nx = (dir_q == 3'd7) ? DONE : ISSUE;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Classify the scanner result: empty or enemy square is legal, enemy is a capture
   always_comb begin
      legal      = 1'b0;
      is_capture = 1'b0;
      if (on_board(pos_q, dir_q)) begin
         if (bus.scan_piece == 4'h0) begin
            legal = 1'b1;
         end else if (bus.scan_piece[3] != side_q) begin
            legal      = 1'b1;
            is_capture = 1'b1;
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Counts cycles spent in WAIT for the scanner latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              wait_cnt <= 2'd0;
      else if (state == WAIT)  wait_cnt <= wait_cnt + 2'd1;
      else                     wait_cnt <= 2'd0;
   end

   // Request latch, direction stepping and result accumulation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         board_q <= '0;
         pos_q   <= '0;
         side_q  <= 1'b0;
         dir_q   <= '0;
         mask_q  <= '0;
         cap_q   <= '0;
         cnt_q   <= '0;
      end else if (accept) begin
         board_q <= bus.board_in;
         pos_q   <= bus.square;
         side_q  <= bus.side;
         dir_q   <= '0;
         mask_q  <= '0;
         cap_q   <= '0;
         cnt_q   <= '0;
      end else if (capture) begin
         if (legal) begin
            mask_q[bus.scan_target] <= 1'b1;
            cnt_q                   <= cnt_q + 4'd1;
         end
         if (is_capture) cap_q[bus.scan_target] <= 1'b1;
         if (dir_q != 3'd7) dir_q <= dir_q + 3'd1;
      end
   end

   assign bus.scan_board   = board_q;
   assign bus.scan_pos     = pos_q;
   assign bus.scan_dir     = dir_q;
   assign bus.busy         = (state == ISSUE) || (state == WAIT);
   assign bus.done         = (state == DONE);
   assign bus.move_mask    = mask_q;
   assign bus.capture_mask = cap_q;
   assign bus.move_count   = cnt_q;

endmodule

// File: tb/tb_knight_move_sequencer.sv
// Bench for knight_move_sequencer: two instances (SCAN_LAT 1 and 2), each
// with a latency-accurate scanner model, checked against a coordinate-based
// knight move reference.
module tb_knight_move_sequencer;

   localparam int DC [8] = '{-2, -1, 1, 2, 2, 1, -1, -2};
   localparam int DR [8] = '{-1, -2, -2, -1, 1, 2, 2, 1};

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start1, start2, abort_i, side_i;
   logic [5:0]   square_i;
   logic [255:0] board_i;
   int           sel = 0;
   int           checks = 0;
   int           failures = 0;

   always #5 clk = ~clk;

   knight_move_sequencer_if if1 ();
   knight_move_sequencer_if if2 ();

   knight_move_sequencer #(.SCAN_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
   knight_move_sequencer #(.SCAN_LAT(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

   assign if1.start = start1;    assign if2.start = start2;
   assign if1.abort = abort_i;   assign if2.abort = abort_i;
   assign if1.square = square_i; assign if2.square = square_i;
   assign if1.side = side_i;     assign if2.side = side_i;
   assign if1.board_in = board_i; assign if2.board_in = board_i;

   // Scanner: knight target and its nibble; off-board directions return junk
   function automatic logic [9:0] scanner(input logic [5:0] pos, input logic [2:0] dir,
                                          input logic [255:0] bd);
      int c, r, t;
      c = int'(pos[2:0]) + DC[dir];
      r = int'(pos[5:3]) + DR[dir];
      if (c < 0 || c > 7 || r < 0 || r > 7) return 10'($urandom);
      t = r * 8 + c;
      return {6'(t), bd[4*t +: 4]};
   endfunction

   logic [9:0] s1_q, s2_a, s2_b;
   always @(posedge clk) s1_q <= scanner(if1.scan_pos, if1.scan_dir, if1.scan_board);
   always @(posedge clk) begin
      s2_a <= scanner(if2.scan_pos, if2.scan_dir, if2.scan_board);
      s2_b <= s2_a;
   end
   assign if1.scan_target = s1_q[9:4]; assign if1.scan_piece = s1_q[3:0];
   assign if2.scan_target = s2_b[9:4]; assign if2.scan_piece = s2_b[3:0];

   logic         busy_s, done_s;
   logic [2:0]   dir_s;
   logic [5:0]   pos_s;
   logic [255:0] sb_s;
   logic [63:0]  mm_s, cm_s;
   logic [3:0]   mc_s;
   assign busy_s = (sel == 1) ? if2.busy : if1.busy;
   assign done_s = (sel == 1) ? if2.done : if1.done;
   assign dir_s  = (sel == 1) ? if2.scan_dir : if1.scan_dir;
   assign pos_s  = (sel == 1) ? if2.scan_pos : if1.scan_pos;
   assign sb_s   = (sel == 1) ? if2.scan_board : if1.scan_board;
   assign mm_s   = (sel == 1) ? if2.move_mask : if1.move_mask;
   assign cm_s   = (sel == 1) ? if2.capture_mask : if1.capture_mask;
   assign mc_s   = (sel == 1) ? if2.move_count : if1.move_count;

   // Reference: knight moves over the first ndirs directions
   function automatic void ref_scan(input logic [255:0] bd, input logic [5:0] sq, input logic sd,
                                    input int ndirs, output logic [63:0] mm,
                                    output logic [63:0] cm, output logic [3:0] mc);
      int c, r, t, cnt;
      logic [3:0] p;
      mm = '0; cm = '0; cnt = 0;
      for (int d = 0; d < ndirs; d++) begin
         c = int'(sq) % 8 + DC[d];
         r = int'(sq) / 8 + DR[d];
         if (c >= 0 && c <= 7 && r >= 0 && r <= 7) begin
            t = r * 8 + c;
            p = bd[4*t +: 4];
            if (p == 4'h0) begin
               mm[t] = 1'b1; cnt++;
            end else if (p[3] != sd) begin
               mm[t] = 1'b1; cm[t] = 1'b1; cnt++;
            end
         end
      end
      mc = 4'(cnt);
   endfunction

   function automatic logic [255:0] rand_board();
      logic [255:0] bd = '0;
      for (int i = 0; i < 64; i++)
         if ($urandom_range(0, 1) == 1) bd[4*i +: 4] = 4'($urandom_range(1, 15));
      return bd;
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " busy"}, 256'(busy_s), 256'(1'b0));
      chk({tag, " done"}, 256'(done_s), 256'(1'b0));
      chk({tag, " dir"}, 256'(dir_s), 256'(3'd0));
      chk({tag, " pos"}, 256'(pos_s), 256'(6'd0));
      chk({tag, " board"}, sb_s, 256'(0));
      chk({tag, " mask"}, 256'(mm_s), 256'(64'd0));
      chk({tag, " cap"}, 256'(cm_s), 256'(64'd0));
      chk({tag, " count"}, 256'(mc_s), 256'(4'd0));
   endtask

   // One full scan on instance s (0: SCAN_LAT=1, 1: SCAN_LAT=2); inputs are
   // scrambled while busy and must not matter
   task automatic run_scan(input int s, input logic [255:0] bd, input logic [5:0] sq,
                           input logic sd, input string tag);
      logic [63:0] em, ec;
      logic [3:0]  en;
      int n, lat;
      lat = (s == 1) ? 2 : 1;
      sel = s;
      board_i = bd; square_i = sq; side_i = sd;
      if (s == 1) start2 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; start2 = 1'b0;
      board_i = rand_board(); square_i = 6'($urandom); side_i = ~sd;
      chk({tag, " busy"}, 256'(busy_s), 256'(1'b1));
      chk({tag, " pos"}, 256'(pos_s), 256'(sq));
      n = 0;
      while (done_s !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " latency"}, 256'(n), 256'(8 * (1 + lat)));
      ref_scan(bd, sq, sd, 8, em, ec, en);
      chk({tag, " mask"}, 256'(mm_s), 256'(em));
      chk({tag, " cap"}, 256'(cm_s), 256'(ec));
      chk({tag, " count"}, 256'(mc_s), 256'(en));
      chk({tag, " busy_done"}, 256'(busy_s), 256'(1'b0));
      @(negedge clk);
      chk({tag, " done_pulse"}, 256'(done_s), 256'(1'b0));
      chk({tag, " mask_hold"}, 256'(mm_s), 256'(em));
   endtask

   logic [255:0] b;
   logic [63:0]  em, ec;
   logic [3:0]   en;
   int           first, ndone;
   logic [5:0]   sq;
   logic         sd;

   initial begin
      rst_n = 1'b1; start1 = 1'b0; start2 = 1'b0; abort_i = 1'b0;
      side_i = 1'b0; square_i = '0; board_i = '0;
      #2 rst_n = 1'b0;
      #1;
      sel = 0; chk_reset("rst1");
      sel = 1; chk_reset("rst2");
      @(negedge clk);
      rst_n = 1'b1;

      // Empty board, centre square: all eight moves
      run_scan(0, '0, 6'd27, 1'b0, "e27");
      em = (64'd1 << 10) | (64'd1 << 12) | (64'd1 << 17) | (64'd1 << 21) |
           (64'd1 << 33) | (64'd1 << 37) | (64'd1 << 42) | (64'd1 << 44);
      chk("e27 mask_const", 256'(mm_s), 256'(em));
      chk("e27 count_const", 256'(mc_s), 256'(4'd8));

      // Corner square: only two moves
      run_scan(0, '0, 6'd0, 1'b0, "e0");
      chk("e0 mask_const", 256'(mm_s), 256'((64'd1 << 10) | (64'd1 << 17)));
      chk("e0 count_const", 256'(mc_s), 256'(4'd2));

      // Enemy on 10 captured, own piece on 17 blocks
      b = '0; b[4*10 +: 4] = 4'hA; b[4*17 +: 4] = 4'h2;
      run_scan(0, b, 6'd27, 1'b0, "blk");
      chk("blk mask_const", 256'(mm_s), 256'(em & ~(64'd1 << 17)));
      chk("blk cap_const", 256'(cm_s), 256'(64'd1 << 10));
      chk("blk count_const", 256'(mc_s), 256'(4'd7));

      // Random boards on both latencies
      for (int k = 0; k < 6; k++)
         run_scan(0, rand_board(), 6'($urandom), 1'($urandom), "rnd1");
      for (int k = 0; k < 3; k++)
         run_scan(1, rand_board(), 6'($urandom), 1'($urandom), "rnd2");

      // Extra starts while busy (edges 3, 6) and while in DONE are ignored
      sel = 0;
      b = rand_board(); sq = 6'($urandom); sd = 1'($urandom);
      board_i = b; square_i = sq; side_i = sd; start1 = 1'b1;
      @(negedge clk);
      first = -1; ndone = 0;
      for (int i = 1; i <= 24; i++) begin
         start1 = (i == 3 || i == 6 || (first >= 0 && i == first + 1)) ? 1'b1 : 1'b0;
         @(negedge clk);
         if (done_s === 1'b1) begin
            ndone++;
            if (first < 0) first = i;
         end
      end
      start1 = 1'b0;
      chk("restart ndone", 256'(ndone), 256'(1));
      chk("restart latency", 256'(first), 256'(16));
      chk("restart idle", 256'(busy_s), 256'(1'b0));
      ref_scan(b, sq, sd, 8, em, ec, en);
      chk("restart mask", 256'(mm_s), 256'(em));
      chk("restart count", 256'(mc_s), 256'(en));

      // Start with abort in IDLE is accepted; abort at edge 5 cancels after two directions
      b = rand_board(); sq = 6'd27; sd = 1'($urandom);
      board_i = b; square_i = sq; side_i = sd; start1 = 1'b1; abort_i = 1'b1;
      @(negedge clk);
      start1 = 1'b0; abort_i = 1'b0;
      chk("abort accepted", 256'(busy_s), 256'(1'b1));
      ndone = 0;
      for (int i = 1; i <= 20; i++) begin
         abort_i = (i == 5) ? 1'b1 : 1'b0;
         @(negedge clk);
         if (done_s === 1'b1) ndone++;
         if (i == 5) chk("abort busy", 256'(busy_s), 256'(1'b0));
      end
      abort_i = 1'b0;
      chk("abort no_done", 256'(ndone), 256'(0));
      ref_scan(b, sq, sd, 2, em, ec, en);
      chk("abort mask", 256'(mm_s), 256'(em));
      chk("abort cap", 256'(cm_s), 256'(ec));
      chk("abort count", 256'(mc_s), 256'(en));
      abort_i = 1'b1;
      @(negedge clk); @(negedge clk);
      abort_i = 1'b0;
      chk("idle abort busy", 256'(busy_s), 256'(1'b0));
      chk("idle abort mask", 256'(mm_s), 256'(em));

      // Reset during WAIT of direction 4 clears everything without a clock edge
      board_i = '0; square_i = 6'd27; side_i = 1'b0; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      for (int i = 0; i < 9; i++) @(negedge clk);
      chk("midrst dir", 256'(dir_s), 256'(3'd4));
      chk("midrst partial", 256'(mc_s), 256'(4'd4));
      rst_n = 1'b0;
      #1;
      chk_reset("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      run_scan(1, '0, 6'd27, 1'b0, "lat2");
      chk("lat2 count_const", 256'(mc_s), 256'(4'd8));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/knight_move_sequencer.md
KNIGHT_MOVE_SEQUENCER -- requirements
Module: knight_move_sequencer

Interface
REQ-001 Parameter SCAN_LAT, default 1, cycles from scanner direction/position change to valid scanner result (legal 1..3).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a scan; sampled only in IDLE.
REQ-005 abort  input  1  synchronous cancel of a scan in progress.
REQ-006 square  input  6  origin square, index = row*8 + col.
REQ-007 side  input  1  mover colour, 0 white, 1 black.
REQ-008 board_in  input  256  board, square n in bits [4n+3:4n].
REQ-009 scan_board  output  256  latched board driven to the scanner.
REQ-010 scan_pos  output  6  latched origin square driven to the scanner.
REQ-011 scan_dir  output  3  knight direction code 0..7 driven to the scanner.
REQ-012 scan_target  input  6  scanner-returned target square.
REQ-013 scan_piece  input  4  scanner-returned target nibble.
REQ-014 busy  output  1  high from start acceptance until DONE.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 move_mask  output  64  bit n set = legal knight move to square n.
REQ-017 capture_mask  output  64  bit n set = legal move that captures.
REQ-018 move_count  output  4  number of legal moves, 0..8.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-020 IDLE with start=1: latch board_in->scan_board, square->scan_pos, side; clear both masks and move_count; scan_dir=0; busy=1; go ISSUE.
REQ-021 start while busy or in DONE is ignored.
REQ-022 ISSUE lasts exactly 1 cycle, then WAIT.
REQ-023 WAIT lasts exactly SCAN_LAT cycles; scan_target/scan_piece are sampled on the edge that ends WAIT (capture edge).
REQ-024 After capture: if scan_dir<7, increment scan_dir and go ISSUE; if scan_dir=7, go DONE.
REQ-025 DONE lasts 1 cycle with done=1, busy=0, then IDLE; done is 0 in every other state.
REQ-026 Accepted start edge to first edge in DONE = 8*(1+SCAN_LAT) edges.
REQ-027 On-board predicate (col=square%8, row=square/8): dir0 col>=2,row>=1; dir1 col>=1,row>=2; dir2 col<=6,row>=2; dir3 col<=5,row>=1; dir4 col<=5,row<=6; dir5 col<=6,row<=5; dir6 col>=1,row<=5; dir7 col>=2,row<=6.
REQ-028 Off-board direction: scanner result ignored, no output changes.
REQ-029 Piece encoding: 4'h0 empty; bit3 = colour; nonzero = occupied.
REQ-030 On-board and empty: set move_mask[scan_target].
REQ-031 On-board, occupied, bit3 != side: set move_mask[scan_target] and capture_mask[scan_target].
REQ-032 On-board, occupied, bit3 == side: no change.
REQ-033 move_count increments by 1 on each capture edge setting a move_mask bit; saturation unreachable (max 8).
REQ-034 Masks and move_count hold after DONE until next accepted start.
REQ-035 abort=1 in ISSUE or WAIT: next state IDLE, busy=0, done never pulses, masks/count hold partial values; abort in IDLE/DONE ignored.
REQ-036 abort and start same cycle in IDLE: start accepted.
REQ-037 board_in and square changes while busy have no effect.

Reset
REQ-038 rst_n=0 at any time, including mid-scan: immediately state IDLE, busy=0, done=0, scan_dir=0, scan_pos=0, scan_board=0, masks=0, move_count=0.
REQ-039 First start accepted on first rising edge after rst_n deasserts.

Verification
REQ-040 Empty board, square=27, side=0, SCAN_LAT=1, real scanner: done 16 edges after start; move_count=8; move_mask bits {10,17,33,42,44,37,21,12}; capture_mask=0.
REQ-041 Empty board, square=0: move_count=2; move_mask bits {17,10} only (dirs 4,5).
REQ-042 square=27, side=0, nibble10=4'hA, nibble17=4'h2: move_mask bit10=1, bit17=0; capture_mask only bit10; move_count=7.
REQ-043 start pulsed at cycles 3 and 6 of a scan: single done; abort at cycle 5 of new scan: busy=0 next cycle, no done.
REQ-044 rst_n low during WAIT of dir 4: outputs zero immediately with no clock edge; SCAN_LAT=2 rerun: done 24 edges after start.
